// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: command encodings, FSM states,
// quarter-bit phase names and the divider calculation.
package i2c_pkg;

    // Command field data[9:8]
    localparam logic [1:0] CMD_WRITE     = 2'b00;
    localparam logic [1:0] CMD_READ_ACK  = 2'b01;
    localparam logic [1:0] CMD_READ_NACK = 2'b10;
    localparam logic [1:0] CMD_STOP      = 2'b11;

    // data[10] requests a (repeated) START ahead of a WRITE
    localparam int START_BIT = 10;

    // Bus-level state; HOLD owns the bus with SCL low between commands
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_XFER  = 3'd2,
        ST_STOP  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Quarter-bit phases within one START, bit or STOP
    localparam logic [1:0] Q_SET    = 2'd0;
    localparam logic [1:0] Q_RISE   = 2'd1;
    localparam logic [1:0] Q_SAMPLE = 2'd2;
    localparam logic [1:0] Q_FALL   = 2'd3;

    // Clocks per quarter bit, rounded up so SCL never exceeds the target
    function automatic int calc_div(input int clk_hz, input int scl_hz);
        int d;
        d = (clk_hz + 4 * scl_hz - 1) / (4 * scl_hz);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/i2c_qdiv.sv
// Quarter-bit tick generator. Counts DIV clocks while run=1 and emits a
// one-cycle tick; hold=1 reloads the count so the current quarter restarts.
module i2c_qdiv #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run & ~hold & (cnt == LAST);

    // Free-running count while active; idle, hold and wrap all return to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || hold || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// I2C master: one command per CPU write (start+write, write, read with ACK,
// read with NACK, stop), open-drain pad control and SCL clock stretching.
//
// Command handshake: wr is a one-cycle strobe sampled on the rising clock
// edge; it is taken only when busy=0 in that same cycle, otherwise it is
// dropped. busy rises the cycle after acceptance and falls in the cycle the
// FSM leaves START, XFER or STOP, so a wr coinciding with completion is lost.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK      = 3579545,
    parameter int SCL_FREQ = 400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [10:0] data,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        nack,
    output logic        busy,
    output logic        scl_o,
    output logic        sda_o,
    input  logic        scl_i,
    input  logic        sda_i
);

    localparam int I2C_DIV = calc_div(CLK, SCL_FREQ);

    state_t      state;
    state_t      state_next;
    logic        take;
    logic        tick;
    logic        hold;
    logic [1:0]  q;
    logic [3:0]  bitcnt;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [1:0]  cmd_r;
    logic        restart;
    logic        is_read;

    assign is_read = (cmd_r == CMD_READ_ACK) || (cmd_r == CMD_READ_NACK);

    // A slave holding SCL low after we release it freezes the rise quarter
    assign hold = (q == Q_RISE) && !scl_i;

    i2c_qdiv #(
        .DIV (I2C_DIV)
    ) u_qdiv (
        .clk   (clk),
        .reset (reset),
        .run   (busy),
        .hold  (hold),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: command decode in IDLE/HOLD, phase-3 exits elsewhere
    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr && (data[9:8] == CMD_WRITE)) begin
                    state_next = ST_START;
                    take       = 1'b1;
                end
            end
            ST_HOLD: begin
                if (wr) begin
                    take = 1'b1;
                    if (data[9:8] == CMD_STOP) begin
                        state_next = ST_STOP;
                    end else if ((data[9:8] == CMD_WRITE) && data[START_BIT]) begin
                        state_next = ST_START;
                    end else begin
                        state_next = ST_XFER;
                    end
                end
            end
            ST_START: begin
                if (tick && (q == Q_FALL)) state_next = ST_XFER;
            end
            ST_XFER: begin
                if (tick && (q == Q_FALL) && (bitcnt == 4'd8)) state_next = ST_HOLD;
            end
            ST_STOP: begin
                if (tick && (q == Q_FALL)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pad and busy decode; each phase keeps the levels set on entry
    always_comb begin
        busy  = 1'b0;
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state)
            ST_START: begin
                busy = 1'b1;
                // q0 leaves SCL where it was: high from IDLE, low from HOLD
                if (q == Q_SET) scl_o = ~restart;
                else            scl_o = (q != Q_FALL);
                sda_o = (q == Q_SET) || (q == Q_RISE);
            end
            ST_XFER: begin
                busy  = 1'b1;
                scl_o = (q == Q_RISE) || (q == Q_SAMPLE);
                if (bitcnt == 4'd8) sda_o = is_read ? (cmd_r == CMD_READ_NACK) : 1'b1;
                else                sda_o = is_read ? 1'b1 : tx_sh[7];
            end
            ST_STOP: begin
                busy  = 1'b1;
                scl_o = (q != Q_SET);
                sda_o = (q == Q_SAMPLE) || (q == Q_FALL);
            end
            ST_HOLD: begin
                scl_o = 1'b0;
                sda_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Phase/bit counters, shift registers and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q        <= Q_SET;
            bitcnt   <= 4'd0;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            cmd_r    <= CMD_WRITE;
            restart  <= 1'b0;
            nack     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (take) begin
                q       <= Q_SET;
                bitcnt  <= 4'd0;
                cmd_r   <= data[9:8];
                restart <= (state == ST_HOLD);
                nack    <= 1'b0;
                if (data[9:8] == CMD_WRITE) tx_sh <= data[7:0];
            end else if (tick) begin
                q <= q + 2'd1;
                if (state == ST_XFER) begin
                    // Sample late in the high period, when SDA is settled
                    if (q == Q_SAMPLE) begin
                        if (is_read && (bitcnt != 4'd8)) rx_sh <= {rx_sh[6:0], sda_i};
                        if (!is_read && (bitcnt == 4'd8)) nack <= sda_i;
                        if (is_read && (bitcnt == 4'd8)) begin
                            rd_data  <= rx_sh;
                            rd_valid <= 1'b1;
                        end
                    end
                    if (q == Q_FALL) begin
                        if (bitcnt == 4'd8) begin
                            bitcnt <= 4'd0;
                        end else begin
                            bitcnt <= bitcnt + 4'd1;
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule
